joy_conditioner: RTL and testbench
==================================

Name: joy_conditioner

Overview:
- Per-player digital joystick and button conditioner, generalising the existing 8-way opposing-direction resolver to N players and selectable resolution policies.
- Adds 4-way restriction and frame-locked autofire.
- Sits between the keyboard/joystick OR-merge in the emu top level and the game core's active-low input ports. Inversion stays in the top level.

Parameters:
- PLAYERS, 2, number of independent player channels.
- BUTTONS, 4, buttons per player.
- AF_HALF, 3, autofire half-period in frame_tick pulses. Must be ≥ 1.

Ports:
- clk  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- socd_mode  in  2  opposing-pair policy: 00 last-wins, 01 neutral, 10 first-wins, 11 treated as 00.
- way4  in  1  1 = restrict output to 4-way.
- af_en  in  BUTTONS  per-button autofire enable, shared by all players.
- frame_tick  in  1  one-clk pulse per video frame.
- dir_in  in  PLAYERS*4  per player p, bits [4p+3:4p] = {up, down, left, right}, active-high, asynchronous to clk.
- btn_in  in  PLAYERS*BUTTONS  active-high raw buttons, asynchronous to clk.
- dir_out  out  PLAYERS*4  conditioned directions, same bit order as dir_in.
- btn_out  out  PLAYERS*BUTTONS  conditioned buttons.

Behaviour:
- Reset values:
  - All outputs 0.
  - Sync stages 0.
  - last/first pair registers 00.
  - axis register 0 (vertical).
  - Autofire counter 0; autofire phase 1.
- Input sync: s1 <= in, s2 <= s1. Edge = s1 & ~s2. Outputs are registered from s1.
- Latency: an input change appears on the outputs on the 2nd rising clk edge after it is sampled.
- Each opposing pair (U/D, L/R) is resolved independently per player. When only one member is held, output it unchanged. When both are held:
  - Last-wins: output the member whose edge occurred most recently. On a same-cycle edge of both, U beats D and L beats R.
  - Neutral: output 00.
  - First-wins: output the member held alone immediately before the pair became 11. If both went from 00 to 11 in the same cycle, U or L wins.
- Pair registers update every cycle regardless of mode, so a socd_mode change takes effect on the next cycle with no state loss.
- 4-way (way4 = 1), applied after pair resolution:
  - If exactly one axis is active, output it and set axis to that axis.
  - If both axes are active, output only the axis recorded in axis; the other axis outputs 00.
  - If both axes become active in the same cycle from neutral, vertical wins.
  - The axis register tracks even when way4 = 0.
- Autofire:
  - A single counter shared by all channels advances on frame_tick.
  - When it reaches AF_HALF-1 it wraps to 0 and phase toggles.
  - btn_out = s1 & (af_en ? phase : 1).
  - phase does not reset on a button press.
- frame_tick held high counts one tick per clk.
- RESET mid-operation clears everything asynchronously. Outputs stay 0 until the input propagates 2 clocks after RESET deasserts.
- Players are fully independent; no cross-channel interaction.

Test Plan:
- Reset then idle inputs → all outputs 0; after RESET release, P0 right held → dir_out[3:0] = 0001 on the 2nd clk.
- Last-wins: P0 R held, L added 10 clks later → 0010; release L → 0001; R and L pressed in the same cycle from 00 → 0010.
- Neutral mode, U+D held → 0000. Switch socd_mode to 10 with D pressed first → 0100 on the next clk, no transient.
- First-wins, L held then R added → 0010; release L → 0001.
- way4 = 1, U held then R added → 1000; release U → 0001; U+R simultaneously from neutral → 1000.
- AF_HALF = 3, af_en = 0001, P1 button 0 held, 12 frame_ticks → btn_out bit toggles every 3 ticks; P0 button 1 held simultaneously stays steady at 1.

Source files
------------

// File: rtl/joy_conditioner.sv
// Per-player joystick/button conditioner: input sync, opposing-pair resolution,
// optional 4-way restriction and frame-locked autofire shared across players.

module joy_channel #(
    parameter int BUTTONS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         socd_mode_i,
    input  logic               way4_i,
    input  logic [BUTTONS-1:0] af_en_i,
    input  logic               af_phase_i,
    input  logic [3:0]         dir_i,
    input  logic [BUTTONS-1:0] btn_i,
    output logic [3:0]         dir_o,
    output logic [BUTTONS-1:0] btn_o
);
    logic [3:0]         dir_s1_q, dir_s2_q, edge_w;
    logic [BUTTONS-1:0] btn_s1_q;
    logic [1:0]         vlast_q, vlast_d, hlast_q, hlast_d;
    logic [1:0]         vfirst_q, vfirst_d, hfirst_q, hfirst_d;
    logic [1:0]         rv, rh;
    logic               vact, hact;
    logic               axis_q, axis_d;
    logic [3:0]         dir_q, dir_d;
    logic [BUTTONS-1:0] btn_q, btn_d;

    // Pair encoding {a, b}: a is U (or L) and wins any same-cycle tie.
    function automatic logic [1:0] next_last(input logic [1:0] edg, input logic [1:0] last);
        if (edg[1])      return 2'b10;
        else if (edg[0]) return 2'b01;
        else             return last;
    endfunction

    function automatic logic [1:0] next_first(input logic [1:0] held, input logic [1:0] first);
        if (held != 2'b11)       return held;
        else if (first == 2'b01) return 2'b01;
        else                     return 2'b10;
    endfunction

    function automatic logic [1:0] resolve(input logic [1:0] held, input logic [1:0] last,
                                           input logic [1:0] first, input logic [1:0] mode);
        if (held != 2'b11) return held;
        case (mode)
            2'b01:   return 2'b00;
            2'b10:   return first;
            default: return (last == 2'b01) ? 2'b01 : 2'b10;
        endcase
    endfunction

    always_comb begin
        edge_w   = dir_s1_q & ~dir_s2_q;
        vlast_d  = next_last(edge_w[3:2], vlast_q);
        hlast_d  = next_last(edge_w[1:0], hlast_q);
        vfirst_d = next_first(dir_s1_q[3:2], vfirst_q);
        hfirst_d = next_first(dir_s1_q[1:0], hfirst_q);
        rv       = resolve(dir_s1_q[3:2], vlast_d, vfirst_d, socd_mode_i);
        rh       = resolve(dir_s1_q[1:0], hlast_d, hfirst_d, socd_mode_i);
        vact     = |rv;
        hact     = |rh;
        // Neutral parks axis on vertical, so both axes arriving together pick vertical.
        axis_d   = (vact && hact) ? axis_q : hact;
        dir_d    = {rv, rh};
        if (way4_i && vact && hact)
            dir_d = axis_d ? {2'b00, rh} : {rv, 2'b00};
        btn_d    = btn_s1_q & (~af_en_i | {BUTTONS{af_phase_i}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_s1_q <= '0;
            dir_s2_q <= '0;
            btn_s1_q <= '0;
            vlast_q  <= '0;
            hlast_q  <= '0;
            vfirst_q <= '0;
            hfirst_q <= '0;
            axis_q   <= 1'b0;
            dir_q    <= '0;
            btn_q    <= '0;
        end else begin
            dir_s1_q <= dir_i;
            dir_s2_q <= dir_s1_q;
            btn_s1_q <= btn_i;
            vlast_q  <= vlast_d;
            hlast_q  <= hlast_d;
            vfirst_q <= vfirst_d;
            hfirst_q <= hfirst_d;
            axis_q   <= axis_d;
            dir_q    <= dir_d;
            btn_q    <= btn_d;
        end
    end

    assign dir_o = dir_q;
    assign btn_o = btn_q;
endmodule

module joy_conditioner #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 4,
    parameter int AF_HALF = 3
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic [1:0]                 socd_mode,
    input  logic                       way4,
    input  logic [BUTTONS-1:0]         af_en,
    input  logic                       frame_tick,
    input  logic [PLAYERS*4-1:0]       dir_in,
    input  logic [PLAYERS*BUTTONS-1:0] btn_in,
    output logic [PLAYERS*4-1:0]       dir_out,
    output logic [PLAYERS*BUTTONS-1:0] btn_out
);
    localparam int CW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

    logic [CW-1:0] af_cnt_q, af_cnt_d;
    logic          af_phase_q, af_phase_d;

    always_comb begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (frame_tick) begin
            if (af_cnt_q == CW'(AF_HALF - 1)) begin
                af_cnt_d   = '0;
                af_phase_d = ~af_phase_q;
            end else begin
                af_cnt_d = af_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        joy_channel #(.BUTTONS(BUTTONS)) u_chan (
            .clk         (clk),
            .rst         (RESET),
            .socd_mode_i (socd_mode),
            .way4_i      (way4),
            .af_en_i     (af_en),
            .af_phase_i  (af_phase_q),
            .dir_i       (dir_in[4*p +: 4]),
            .btn_i       (btn_in[BUTTONS*p +: BUTTONS]),
            .dir_o       (dir_out[4*p +: 4]),
            .btn_o       (btn_out[BUTTONS*p +: BUTTONS])
        );
    end
endmodule

// File: tb/tb_joy_conditioner.sv
// Scoreboarded bench for joy_conditioner: press-timestamp reference model,
// directed scenarios followed by randomized stimulus.

module tb_joy_conditioner;
    localparam int PLAYERS = 2;
    localparam int BUTTONS = 4;
    localparam int AF_HALF = 3;

    logic                       clk = 1'b0;
    logic                       RESET = 1'b1;
    logic [1:0]                 socd_mode = 2'b00;
    logic                       way4 = 1'b0;
    logic [BUTTONS-1:0]         af_en = '0;
    logic                       frame_tick = 1'b0;
    logic [PLAYERS*4-1:0]       dir_in = '0;
    logic [PLAYERS*BUTTONS-1:0] btn_in = '0;
    logic [PLAYERS*4-1:0]       dir_out;
    logic [PLAYERS*BUTTONS-1:0] btn_out;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [PLAYERS*4-1:0]       dir;
        logic [PLAYERS*BUTTONS-1:0] btn;
    } exp_t;
    exp_t sb_q[$];

    joy_conditioner #(.PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .AF_HALF(AF_HALF)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .socd_mode  (socd_mode),
        .way4       (way4),
        .af_en      (af_en),
        .frame_tick (frame_tick),
        .dir_in     (dir_in),
        .btn_in     (btn_in),
        .dir_out    (dir_out),
        .btn_out    (btn_out)
    );

    initial forever #5 clk = ~clk;

    // Reference model state: sampled inputs, cycle of each direction's press, axis memory.
    logic [PLAYERS*4-1:0]       m_dir_s;
    logic [PLAYERS*BUTTONS-1:0] m_btn_s;
    int   m_press[PLAYERS*4];
    logic m_axis[PLAYERS];
    logic m_act[PLAYERS];
    int   m_cyc = 0;
    int   m_ticks = 0;

    function automatic logic [1:0] m_pair(input logic a, input logic b, input int t_a,
                                          input int t_b, input logic [1:0] mode);
        if (!(a && b)) return {a, b};
        if (mode == 2'b01) return 2'b00;
        if (mode == 2'b10) return (t_a <= t_b) ? 2'b10 : 2'b01;
        return (t_a >= t_b) ? 2'b10 : 2'b01;
    endfunction

    initial begin
        exp_t e;
        logic [1:0] v, h;
        logic ax, phase;
        forever begin
            @(posedge clk);
            m_cyc++;
            e = '0;
            if (RESET) begin
                m_dir_s = '0;
                m_btn_s = '0;
                m_ticks = 0;
                for (int p = 0; p < PLAYERS; p++) begin
                    m_axis[p] = 1'b0;
                    m_act[p]  = 1'b0;
                end
                for (int i = 0; i < PLAYERS*4; i++) m_press[i] = 0;
            end else begin
                for (int p = 0; p < PLAYERS; p++) begin
                    v = m_pair(m_dir_s[4*p+3], m_dir_s[4*p+2], m_press[4*p+3], m_press[4*p+2], socd_mode);
                    h = m_pair(m_dir_s[4*p+1], m_dir_s[4*p],   m_press[4*p+1], m_press[4*p],   socd_mode);
                    if (v != 0 && h != 0) ax = m_act[p] ? m_axis[p] : 1'b0;
                    else if (v != 0)      ax = 1'b0;
                    else if (h != 0)      ax = 1'b1;
                    else                  ax = m_axis[p];
                    m_axis[p] = ax;
                    m_act[p]  = (v != 0) || (h != 0);
                    e.dir[4*p +: 4] = {v, h};
                    if (way4 && v != 0 && h != 0)
                        e.dir[4*p +: 4] = ax ? {2'b00, h} : {v, 2'b00};
                end
                phase = ((m_ticks / AF_HALF) % 2) == 0;
                for (int i = 0; i < PLAYERS*BUTTONS; i++)
                    e.btn[i] = m_btn_s[i] && (!af_en[i % BUTTONS] || phase);
                if (frame_tick) m_ticks++;
                for (int i = 0; i < PLAYERS*4; i++)
                    if (dir_in[i] && !m_dir_s[i]) m_press[i] = m_cyc;
                m_dir_s = dir_in;
                m_btn_s = btn_in;
            end
            sb_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty t=%0t no expected entry queued", $time);
            end else begin
                e = sb_q.pop_front();
                if (dir_out !== e.dir || btn_out !== e.btn) begin
                    failures++;
                    $display("FAIL sb_cycle t=%0t dir_out=%b expected=%b btn_out=%b expected=%b",
                             $time, dir_out, e.dir, btn_out, e.btn);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        step(3);
        chk("reset_dir", 32'(dir_out), 32'h0);
        chk("reset_btn", 32'(btn_out), 32'h0);
        RESET = 1'b0;
        dir_in[3:0] = 4'b0001;
        step(1); chk("latency_1clk", 32'(dir_out[3:0]), 32'h0);
        step(1); chk("latency_2clk", 32'(dir_out[3:0]), 32'h1);

        // last-wins
        step(10); dir_in[3:0] = 4'b0011;
        step(2);  chk("last_add_L", 32'(dir_out[3:0]), 32'h2);
        dir_in[3:0] = 4'b0001;
        step(2);  chk("last_rel_L", 32'(dir_out[3:0]), 32'h1);
        dir_in[3:0] = 4'b0000; step(3);
        dir_in[3:0] = 4'b0011;
        step(2);  chk("last_tie", 32'(dir_out[3:0]), 32'h2);

        // neutral, then switch to first-wins
        dir_in[3:0] = 4'b0000; step(2);
        socd_mode = 2'b01; dir_in[3:0] = 4'b0100; step(3);
        dir_in[3:0] = 4'b1100;
        step(2);  chk("neutral_UD", 32'(dir_out[3:0]), 32'h0);
        socd_mode = 2'b10;
        step(1);  chk("mode_switch", 32'(dir_out[3:0]), 32'h4);

        // first-wins
        dir_in[3:0] = 4'b0000; step(2);
        dir_in[3:0] = 4'b0010; step(3);
        dir_in[3:0] = 4'b0011;
        step(2);  chk("first_L_then_R", 32'(dir_out[3:0]), 32'h2);
        dir_in[3:0] = 4'b0001;
        step(2);  chk("first_rel_L", 32'(dir_out[3:0]), 32'h1);

        // 4-way
        socd_mode = 2'b00; dir_in[3:0] = 4'b0000; step(2);
        way4 = 1'b1; dir_in[3:0] = 4'b1000; step(3);
        dir_in[3:0] = 4'b1001;
        step(2);  chk("way4_U_then_R", 32'(dir_out[3:0]), 32'h8);
        dir_in[3:0] = 4'b0001;
        step(2);  chk("way4_rel_U", 32'(dir_out[3:0]), 32'h1);
        dir_in[3:0] = 4'b0000; step(3);
        dir_in[3:0] = 4'b1001;
        step(2);  chk("way4_tie", 32'(dir_out[3:0]), 32'h8);

        // autofire: P1 button 0 on autofire, P0 button 1 steady
        way4 = 1'b0; dir_in = '0; af_en = 4'b0001;
        btn_in[BUTTONS] = 1'b1; btn_in[1] = 1'b1;
        step(2);
        chk("af_p1b0_t0", 32'(btn_out[BUTTONS]), 32'h1);
        for (int n = 1; n <= 12; n++) begin
            frame_tick = 1'b1; step(1);
            frame_tick = 1'b0; step(1);
            chk($sformatf("af_p1b0_t%0d", n), 32'(btn_out[BUTTONS]), 32'(((n / AF_HALF) % 2) == 0));
            chk($sformatf("af_p0b1_t%0d", n), 32'(btn_out[1]), 32'h1);
        end

        // mid-operation reset
        dir_in[3:0] = 4'b0001; step(3);
        chk("pre_reset", 32'(dir_out[3:0]), 32'h1);
        RESET = 1'b1; #1;
        chk("async_reset_dir", 32'(dir_out), 32'h0);
        chk("async_reset_btn", 32'(btn_out), 32'h0);
        step(2); RESET = 1'b0;
        step(1); chk("post_reset_1clk", 32'(dir_out[3:0]), 32'h0);
        step(1); chk("post_reset_2clk", 32'(dir_out[3:0]), 32'h1);

        // randomized traffic, all checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            step(1);
            RESET = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) dir_in[$urandom_range(0, PLAYERS*4-1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) btn_in[$urandom_range(0, PLAYERS*BUTTONS-1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) socd_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) way4 = ~way4;
            if ($urandom_range(0, 79) == 0) af_en = BUTTONS'($urandom);
            frame_tick = ($urandom_range(0, 3) == 0);
        end
        RESET = 1'b0;
        frame_tick = 1'b0;
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
